// File: rtl/inst_mem_loader.sv
// Loadable instruction memory: a host streams an image in over a valid/ready
// port, then the fetch stage reads it back with one-cycle registered latency.
module inst_mem_loader #(
    parameter int            A    = 8,
    parameter int            W    = 9,
    parameter logic [W-1:0]  FILL = {W{1'b1}}
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         LoadStart,
    input  logic         LoadValid,
    input  logic [W-1:0] LoadData,
    input  logic         LoadLast,
    output logic         LoadReady,
    output logic         LoadDone,
    output logic [A:0]   LoadCount,
    input  logic         FetchReq,
    input  logic [A-1:0] FetchAddr,
    output logic [W-1:0] InstOut,
    output logic         InstValid,
    output logic         Running
);

    localparam int         DEPTH = 2 ** A;
    localparam logic [A:0] LASTP = (A + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    state_t         state_q;
    logic [A:0]     ptr_q;
    logic [A:0]     ptr_d;
    logic [A:0]     cnt_q;
    logic           ready_q;
    logic           run_q;
    logic           done_q;
    logic [W-1:0]   inst_q;
    logic           ival_q;
    logic           accept;
    logic           fin;
    logic           hit;

    logic [W-1:0]   mem [DEPTH];

    assign accept = (state_q == LOAD) & LoadValid & ~LoadStart;
    // A full memory ends the load even without LoadLast.
    assign fin    = accept & (LoadLast | (ptr_q == LASTP));
    assign ptr_d  = ptr_q + 1'b1;
    assign hit    = {1'b0, FetchAddr} < cnt_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= fin;
            if (LoadStart) begin
                state_q <= LOAD;
                ptr_q   <= '0;
                cnt_q   <= '0;
                ready_q <= 1'b1;
                run_q   <= 1'b0;
            end else if (accept) begin
                ptr_q <= ptr_d;
                cnt_q <= ptr_d;
                if (fin) begin
                    state_q <= RUN;
                    ready_q <= 1'b0;
                    run_q   <= 1'b1;
                end
            end
        end
    end

    // Storage is deliberately left out of reset; LoadCount gates visibility.
    always_ff @(posedge Clk) begin
        if (accept) begin
            mem[ptr_q[A-1:0]] <= LoadData;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            inst_q <= '0;
            ival_q <= 1'b0;
        end else if (FetchReq && state_q == RUN) begin
            inst_q <= hit ? mem[FetchAddr] : FILL;
            ival_q <= 1'b1;
        end else begin
            ival_q <= 1'b0;
        end
    end

    assign LoadReady = ready_q;
    assign LoadDone  = done_q;
    assign LoadCount = cnt_q;
    assign InstOut   = inst_q;
    assign InstValid = ival_q;
    assign Running   = run_q;

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Parametrised, loadable instruction memory for the CSE141L core.
- Boot: a host streams a program image into the memory over a valid/ready port.
- Run: the fetch stage reads instructions with a registered one-cycle latency.
- Fetches beyond the loaded image return a programmable fill word, HALT (all ones) by default, so a short program stops cleanly instead of running into uninitialised storage.
- Sits between the testbench/boot loader and the fetch stage. It replaces the file-initialised combinational ROM.

## Interface
Parameters:
- A, 8: address width. DEPTH = 2**A words.
- W, 9: instruction width.
- FILL, {W{1'b1}}: word returned for addresses at or beyond the loaded image length (HALT).

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- LoadStart  input  1  one-cycle request to begin a new image load.
- LoadValid  input  1  LoadData is valid this cycle.
- LoadData  input  W  instruction word to store.
- LoadLast  input  1  qualifies LoadValid: this is the final word of the image.
- LoadReady  output  1  block accepts a load word this cycle (high only in LOAD).
- LoadDone  output  1  one-cycle pulse on the cycle after the final word is accepted.
- LoadCount  output  A+1  number of words in the current image (0..DEPTH).
- FetchReq  input  1  read request for FetchAddr.
- FetchAddr  input  A  instruction address.
- InstOut  output  W  registered instruction.
- InstValid  output  1  InstOut holds the response to the previous cycle's FetchReq.
- Running  output  1  high in RUN; fetches are serviced only then.

## Operation
- Storage: DEPTH x W array, written only by the load port. Contents are not cleared by Reset.
- States:
  - IDLE (after reset): LoadReady=0, Running=0.
  - LOAD: LoadReady=1.
  - RUN: Running=1.
- Transitions:
  - IDLE -> LOAD on LoadStart.
  - RUN -> LOAD on LoadStart.
  - LoadStart while in LOAD restarts the load: write pointer := 0, count := 0, and any LoadValid in that cycle is dropped.
  - LOAD -> RUN when a word is accepted with LoadLast=1.
  - LOAD -> RUN automatically when the DEPTH-th word is accepted; any LoadLast is then redundant.
- Load accept: LoadValid & LoadReady & !LoadStart.
  - Write mem[ptr] := LoadData.
  - ptr := ptr+1 (A+1-bit pointer, never wraps).
  - LoadCount := ptr+1.
- Entering LOAD sets LoadCount to 0 immediately, on the same edge. The previous image is invalidated.
- LoadDone pulses high for exactly one cycle, the first cycle in RUN after a load.
- Fetch in RUN: on FetchReq, the next cycle presents InstOut = (FetchAddr < LoadCount) ? mem[FetchAddr] : FILL, with InstValid=1.
  - The comparison is unsigned, on A+1 bits with FetchAddr zero-extended.
- FetchReq in IDLE or LOAD is ignored: InstValid=0 on the next cycle and InstOut holds its value.
- InstOut holds its last value whenever InstValid=0.
- An empty image is impossible: an image always contains at least one word, because the LoadLast word is itself stored.

## Timing
- Reset values: state=IDLE, LoadReady=0, LoadDone=0, LoadCount=0, InstOut=0, InstValid=0, Running=0.
- Reset asserted mid-load or mid-fetch returns to IDLE within the same cycle. A partially loaded image is discarded, because LoadCount=0.
- Read latency: 1 cycle, fully pipelined. A fetch can be issued every cycle, one response per request, in order.
- Load throughput: 1 word per cycle while LoadValid is held high.
- LOAD to RUN:
  - The edge that accepts the last word sets state=RUN, so Running=1 and LoadDone=1 in the following cycle.
  - A FetchReq in that cycle is serviced, including a fetch of the just-written last word.
- A FetchReq in the same cycle as a LoadStart from RUN is serviced, reading the old image. Starting from the following cycle, fetches are ignored.

## Test plan
- Reset, then load 3 words 0x001, 0x049, 0x1FF (last flagged). Expect LoadCount 1→2→3, LoadDone one pulse, Running=1. Fetch addr 0,1,2,3 back-to-back: InstOut 0x001, 0x049, 0x1FF, 0x1FF (FILL), each one cycle later with InstValid=1.
- A=2: stream 4 words without LoadLast. Expect auto transition to RUN after the 4th, LoadCount=4, and LoadReady=0 thereafter. A 5th LoadValid is not accepted.
- Fetch in IDLE and during LOAD: InstValid stays 0 and InstOut stays 0.
- Reset asserted after 2 of 5 words: all outputs return to reset values immediately. Reload 1 word 0x0AA: fetch addr 1 returns FILL.
- LoadStart with LoadValid in LOAD after 2 words: the word is dropped and LoadCount=0. The next accepted word lands at address 0.
- Reload from RUN with a shorter image, 1 word after 3: addr 1 now returns FILL. A fetch issued on the LoadStart cycle still returns the old mem[addr].
